// File: rtl/poly_frac_resampler_if.sv
// ---------------------------------------------------------------------------
// poly_frac_resampler_if
// Bundles the streaming and coefficient-bank signals of poly_frac_resampler.
//   master : sample source / bank writer (drives valid_in, ch_in, filter_in,
//            bypass, coeff_wr_en, coeff_addr, coeff_data_in)
//   slave  : the resampler (drives coeff_rd_data, filter_out, ch_out,
//            valid_out, overflow, underflow)
// ---------------------------------------------------------------------------
interface poly_frac_resampler_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int COEFF_WIDTH = 20,
  parameter int N_TAP       = 72,
  parameter int N_CH        = 2,
  parameter int CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
);
  localparam int ADDR_W = $clog2(N_TAP);

  logic                          valid_in;
  logic [CH_W-1:0]               ch_in;
  logic signed [DATA_WIDTH-1:0]  filter_in;
  logic                          bypass;
  logic                          coeff_wr_en;
  logic [ADDR_W-1:0]             coeff_addr;
  logic signed [COEFF_WIDTH-1:0] coeff_data_in;
  logic signed [COEFF_WIDTH-1:0] coeff_rd_data;
  logic signed [DATA_WIDTH-1:0]  filter_out;
  logic [CH_W-1:0]               ch_out;
  logic                          valid_out;
  logic                          overflow;
  logic                          underflow;

  modport master (
    output valid_in, ch_in, filter_in, bypass,
    output coeff_wr_en, coeff_addr, coeff_data_in,
    input  coeff_rd_data, filter_out, ch_out, valid_out, overflow, underflow
  );

  modport slave (
    input  valid_in, ch_in, filter_in, bypass,
    input  coeff_wr_en, coeff_addr, coeff_data_in,
    output coeff_rd_data, filter_out, ch_out, valid_out, overflow, underflow
  );
endinterface

// File: rtl/poly_frac_resampler.sv
// ---------------------------------------------------------------------------
// poly_frac_resampler
// Rational L/M fractional decimator (L < M) built as a polyphase FIR with a
// runtime-writable prototype coefficient bank, time-multiplexed over N_CH
// channels (own delay line and phase accumulator per channel).
//
// Ports:
//   clk   : clock
//   rst_n : synchronous active-low reset (coefficient bank is not reset)
//   bus   : poly_frac_resampler_if.slave
//           valid_in/ch_in/filter_in : input sample stream with channel tag
//           bypass                   : 1-cycle pass-through mode
//           coeff_wr_en/coeff_addr/coeff_data_in : bank write port
//           coeff_rd_data            : bank readback
//           filter_out/ch_out/valid_out : output stream
//           overflow/underflow       : saturation pulses with valid_out
//
// Build option: define COEFF_RDBK_EN to enable combinational coefficient
// readback on coeff_rd_data; otherwise it is tied to zero.
//
// Latency: 3 clk in filter mode, 1 clk in bypass.
// ---------------------------------------------------------------------------
module poly_frac_resampler #(
  parameter int DATA_WIDTH  = 16,
  parameter int DATA_FRAC   = 15,
  parameter int COEFF_WIDTH = 20,
  parameter int COEFF_FRAC  = 18,
  parameter int N_TAP       = 72,
  parameter int L           = 2,
  parameter int M           = 3,
  parameter int N_CH        = 2,
  parameter int CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  poly_frac_resampler_if.slave  bus
);

  localparam int TPP       = N_TAP / L;
  localparam int PROD_W    = DATA_WIDTH + COEFF_WIDTH;
  localparam int GUARD_W   = $clog2(TPP);
  localparam int ACC_W     = PROD_W + GUARD_W;
  localparam int R_W       = (M > 1) ? $clog2(M) : 1;
  localparam int ADDR_W    = $clog2(N_TAP);
  // Output keeps the input's fractional format, so drop the coefficient's
  // fractional bits from the full-precision product.
  localparam int PROD_FRAC = DATA_FRAC + COEFF_FRAC;
  localparam int SHIFT     = PROD_FRAC - DATA_FRAC;

  // Round half-up then saturate; returns {overflow, underflow, sample}.
  function automatic logic [DATA_WIDTH+1:0] round_sat(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] rnd;
    logic signed [ACC_W-1:0] mx;
    logic signed [ACC_W-1:0] mn;
    mx = '0;
    mx[DATA_WIDTH-2:0] = '1;
    mn = ~mx;
    rnd = (a + (ACC_W'(1) <<< (SHIFT - 1))) >>> SHIFT;
    if (rnd > mx) begin
      return {2'b10, mx[DATA_WIDTH-1:0]};
    end else if (rnd < mn) begin
      return {2'b01, mn[DATA_WIDTH-1:0]};
    end
    return {2'b00, rnd[DATA_WIDTH-1:0]};
  endfunction

  // Coefficient bank and per-channel state
  logic signed [COEFF_WIDTH-1:0] h_q  [N_TAP];
  logic signed [COEFF_WIDTH-1:0] h_d  [N_TAP];
  logic signed [DATA_WIDTH-1:0]  dl_q [N_CH][TPP];
  logic signed [DATA_WIDTH-1:0]  dl_d [N_CH][TPP];
  logic [R_W-1:0]                r_q  [N_CH];
  logic [R_W-1:0]                r_d  [N_CH];

  // Stage 0 (delay line written, phase coefficients captured)
  logic                          vld_p0_q, vld_p0_d;
  logic [CH_W-1:0]               ch_p0_q, ch_p0_d;
  logic signed [COEFF_WIDTH-1:0] coef_p0_q [TPP];
  logic signed [COEFF_WIDTH-1:0] coef_p0_d [TPP];

  // Stage 1 (products)
  logic                          vld_p1_q, vld_p1_d;
  logic [CH_W-1:0]               ch_p1_q, ch_p1_d;
  logic signed [PROD_W-1:0]      prod_p1_q [TPP];
  logic signed [PROD_W-1:0]      prod_p1_d [TPP];

  // Stage 2 (output register)
  logic signed [DATA_WIDTH-1:0]  filter_out_q, filter_out_d;
  logic [CH_W-1:0]               ch_out_q, ch_out_d;
  logic                          valid_out_q, valid_out_d;
  logic                          overflow_q, overflow_d;
  logic                          underflow_q, underflow_d;

  logic                          accept;
  logic [R_W-1:0]                r_cur;
  logic [ADDR_W-1:0]             tap_idx;
  logic signed [ACC_W-1:0]       acc;
  logic [DATA_WIDTH+1:0]         rs;

  // Bank write port; out-of-range addresses are dropped.
  always_comb begin
    h_d = h_q;
    if (bus.coeff_wr_en && (int'(bus.coeff_addr) < N_TAP)) begin
      h_d[bus.coeff_addr] = bus.coeff_data_in;
    end
  end

  // ---- stage 0: accept sample, advance phase, snapshot phase coefficients ----
  // The snapshot reads h_q before any same-cycle write lands, so a sample
  // accepted together with a write sees the old coefficient.
  always_comb begin
    dl_d      = dl_q;
    r_d       = r_q;
    vld_p0_d  = 1'b0;
    ch_p0_d   = ch_p0_q;
    coef_p0_d = coef_p0_q;
    tap_idx   = '0;
    accept    = bus.valid_in && (int'(bus.ch_in) < N_CH);
    r_cur     = r_q[bus.ch_in];

    if (accept) begin
      for (int k = TPP - 1; k > 0; k--) begin
        dl_d[bus.ch_in][k] = dl_q[bus.ch_in][k-1];
      end
      dl_d[bus.ch_in][0] = bus.filter_in;
    end

    if (bus.bypass) begin
      // Phases parked at 0 so every channel restarts aligned on exit.
      for (int c = 0; c < N_CH; c++) begin
        r_d[c] = '0;
      end
    end else if (accept) begin
      if (int'(r_cur) < L) begin
        vld_p0_d = 1'b1;
        ch_p0_d  = bus.ch_in;
        for (int k = 0; k < TPP; k++) begin
          tap_idx      = ADDR_W'(k * L + int'(r_cur));
          coef_p0_d[k] = h_q[tap_idx];
        end
        r_d[bus.ch_in] = r_cur + R_W'(M - L);
      end else begin
        r_d[bus.ch_in] = r_cur - R_W'(L);
      end
    end
  end

  // ---- stage 1: full-precision products over the updated delay line ----
  always_comb begin
    vld_p1_d  = vld_p0_q && !bus.bypass;
    ch_p1_d   = ch_p0_q;
    prod_p1_d = prod_p1_q;
    if (vld_p0_q) begin
      for (int k = 0; k < TPP; k++) begin
        prod_p1_d[k] = PROD_W'(dl_q[ch_p0_q][k]) * PROD_W'(coef_p0_q[k]);
      end
    end
  end

  // ---- stage 2: accumulate, round, saturate, or pass through in bypass ----
  always_comb begin
    acc = '0;
    for (int k = 0; k < TPP; k++) begin
      acc = acc + ACC_W'(prod_p1_q[k]);
    end
    rs = round_sat(acc);

    filter_out_d = filter_out_q;
    ch_out_d     = ch_out_q;
    valid_out_d  = 1'b0;
    overflow_d   = 1'b0;
    underflow_d  = 1'b0;
    if (bus.bypass) begin
      filter_out_d = bus.filter_in;
      ch_out_d     = bus.ch_in;
      valid_out_d  = bus.valid_in;
    end else if (vld_p1_q) begin
      filter_out_d = rs[DATA_WIDTH-1:0];
      ch_out_d     = ch_p1_q;
      valid_out_d  = 1'b1;
      overflow_d   = rs[DATA_WIDTH+1];
      underflow_d  = rs[DATA_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    h_q <= h_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < N_CH; c++) begin
        r_q[c] <= '0;
        for (int k = 0; k < TPP; k++) begin
          dl_q[c][k] <= '0;
        end
      end
      vld_p0_q <= 1'b0;
      ch_p0_q  <= '0;
      vld_p1_q <= 1'b0;
      ch_p1_q  <= '0;
      for (int k = 0; k < TPP; k++) begin
        coef_p0_q[k] <= '0;
        prod_p1_q[k] <= '0;
      end
      filter_out_q <= '0;
      ch_out_q     <= '0;
      valid_out_q  <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      r_q          <= r_d;
      dl_q         <= dl_d;
      vld_p0_q     <= vld_p0_d;
      ch_p0_q      <= ch_p0_d;
      coef_p0_q    <= coef_p0_d;
      vld_p1_q     <= vld_p1_d;
      ch_p1_q      <= ch_p1_d;
      prod_p1_q    <= prod_p1_d;
      filter_out_q <= filter_out_d;
      ch_out_q     <= ch_out_d;
      valid_out_q  <= valid_out_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  assign bus.filter_out = filter_out_q;
  assign bus.ch_out     = ch_out_q;
  assign bus.valid_out  = valid_out_q;
  assign bus.overflow   = overflow_q;
  assign bus.underflow  = underflow_q;

`ifdef COEFF_RDBK_EN
  assign bus.coeff_rd_data = (int'(bus.coeff_addr) < N_TAP) ? h_q[bus.coeff_addr] : '0;
`else
  assign bus.coeff_rd_data = '0;
`endif

endmodule

// File: tb/tb_poly_frac_resampler.sv
// ---------------------------------------------------------------------------
// tb_poly_frac_resampler
// Self-checking bench for poly_frac_resampler (default parameters).
// Expected outputs come from stimulus tables or from a behavioural model of
// the L/M polyphase decimator; they are queued with their due cycle and
// checked when valid_out appears.
// ---------------------------------------------------------------------------
module tb_poly_frac_resampler;
  localparam int DW  = 16;
  localparam int CW  = 20;
  localparam int NT  = 72;
  localparam int LF  = 2;
  localparam int MF  = 3;
  localparam int NC  = 2;
  localparam int CHW = 1;
  localparam int TPP = NT / LF;
  localparam int AW  = $clog2(NT);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  poly_frac_resampler_if #(.DATA_WIDTH(DW), .COEFF_WIDTH(CW), .N_TAP(NT),
                           .N_CH(NC), .CH_W(CHW)) bus ();

  poly_frac_resampler #(.DATA_WIDTH(DW), .DATA_FRAC(15), .COEFF_WIDTH(CW),
                        .COEFF_FRAC(18), .N_TAP(NT), .L(LF), .M(MF),
                        .N_CH(NC), .CH_W(CHW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int             cyc;
    logic [DW-1:0]  y;
    logic [CHW-1:0] ch;
    logic           ovf;
    logic           unf;
  } exp_t;

  typedef struct { logic [DW-1:0] x; bit emit; logic [DW-1:0] y; } imp_t;
  typedef struct { int ch; logic [DW-1:0] x; logic [DW-1:0] y; } byp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   out_cnt = 0;
  int   ovf_cnt = 0;
  int   unf_cnt = 0;
  int   ch_cnt [NC];
  int   hist [NC][TPP];
  int   r_m [NC];
  int   coef_m [NT];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", nm, act, req);
    end
  endtask

  // Output monitor / scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (bus.valid_out) begin
      out_cnt++;
      ch_cnt[bus.ch_out]++;
      if (bus.overflow)  ovf_cnt++;
      if (bus.underflow) unf_cnt++;
      n_cmp++;
      if (sbq.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_out cyc=%0d: got y=%h ch=%0d, required no output",
                 cyc, bus.filter_out, bus.ch_out);
      end else begin
        mon_e = sbq.pop_front();
        if (mon_e.cyc != cyc || bus.filter_out !== mon_e.y || bus.ch_out !== mon_e.ch ||
            bus.overflow !== mon_e.ovf || bus.underflow !== mon_e.unf) begin
          n_fail++;
          $display("FAIL sb_out: got cyc=%0d y=%h ch=%0d ovf=%0b unf=%0b, required cyc=%0d y=%h ch=%0d ovf=%0b unf=%0b",
                   cyc, bus.filter_out, bus.ch_out, bus.overflow, bus.underflow,
                   mon_e.cyc, mon_e.y, mon_e.ch, mon_e.ovf, mon_e.unf);
        end
      end
    end else begin
      chk("flags_idle", {bus.overflow, bus.underflow}, 0);
      if (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
        mon_e = sbq.pop_front();
        n_cmp++;
        n_fail++;
        $display("FAIL missing_out cyc=%0d: got no output, required y=%h ch=%0d",
                 cyc, mon_e.y, mon_e.ch);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model of one input cycle.
  task automatic model(input bit v, input int ch, input logic [DW-1:0] x,
                       input bit byp, output bit emit, output exp_t e);
    longint acc;
    longint y;
    logic signed [DW-1:0] xs;
    emit = 1'b0;
    e    = '{cyc: 0, y: '0, ch: '0, ovf: 1'b0, unf: 1'b0};
    xs   = x;
    if (v && ch < NC) begin
      for (int k = TPP - 1; k > 0; k--) hist[ch][k] = hist[ch][k-1];
      hist[ch][0] = int'(xs);
    end
    if (byp) begin
      for (int c = 0; c < NC; c++) r_m[c] = 0;
      if (v) begin
        emit  = 1'b1;
        e.cyc = cyc + 1;
        e.y   = x;
        e.ch  = ch[CHW-1:0];
      end
    end else if (v && ch < NC) begin
      if (r_m[ch] < LF) begin
        acc = 0;
        for (int k = 0; k < TPP; k++)
          acc += longint'(hist[ch][k]) * longint'(coef_m[k*LF + r_m[ch]]);
        y = (acc + 131072) >>> 18;
        if (y > 32767) begin
          e.y = 16'h7FFF; e.ovf = 1'b1;
        end else if (y < -32768) begin
          e.y = 16'h8000; e.unf = 1'b1;
        end else begin
          e.y = y[DW-1:0];
        end
        emit  = 1'b1;
        e.cyc = cyc + 3;
        e.ch  = ch[CHW-1:0];
        r_m[ch] += MF - LF;
      end else begin
        r_m[ch] -= LF;
      end
    end
  endtask

  task automatic drive(input bit v, input int ch, input logic [DW-1:0] x,
                       input bit wr, input int addr, input int cd,
                       input bit tab, input bit t_emit, input logic [DW-1:0] t_y);
    bit   emit;
    exp_t e;
    logic signed [CW-1:0] cs;
    cs                = CW'(cd);
    bus.valid_in      = v;
    bus.ch_in         = CHW'(ch);
    bus.filter_in     = x;
    bus.coeff_wr_en   = wr;
    bus.coeff_addr    = AW'(addr);
    bus.coeff_data_in = cs;
    model(v, ch, x, bus.bypass, emit, e);
    if (tab) begin
      emit  = t_emit;
      e.cyc = cyc + (bus.bypass ? 1 : 3);
      e.y   = t_y;
      e.ch  = CHW'(ch);
      e.ovf = 1'b0;
      e.unf = 1'b0;
    end
    if (emit) sbq.push_back(e);
    if (wr && addr >= 0 && addr < NT) coef_m[addr] = int'(cs);
    step();
    bus.valid_in    = 1'b0;
    bus.coeff_wr_en = 1'b0;
  endtask

  task automatic send(input int ch, input logic [DW-1:0] x);
    drive(1'b1, ch, x, 1'b0, 0, 0, 1'b0, 1'b0, '0);
  endtask

  task automatic wcoef(input int a, input int d);
    drive(1'b0, 0, '0, 1'b1, a, d, 1'b0, 1'b0, '0);
  endtask

  task automatic load_rand();
    for (int a = 0; a < NT; a++) wcoef(a, int'($urandom_range(0, 32767)) - 16384);
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() > 0 && n < 20) begin
      step();
      n++;
    end
    if (sbq.size() > 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending, required 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic flush_future();
    while (sbq.size() > 0 && sbq[$].cyc > cyc) void'(sbq.pop_back());
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    flush_future();
    for (int c = 0; c < NC; c++) begin
      r_m[c] = 0;
      for (int k = 0; k < TPP; k++) hist[c][k] = 0;
    end
    step();
    rst_n = 1'b1;
  endtask

  imp_t imp_tab [12];
  byp_t byp_tab [5];

  initial begin
    int base, b0, b1, bo, bu;
    for (int i = 0; i < 12; i++) begin
      imp_tab[i].x    = (i == 0) ? 16'h4000 : 16'h0000;
      imp_tab[i].emit = (i % 3) != 2;
      imp_tab[i].y    = (i == 0) ? 16'h4000 : 16'h0000;
    end
    byp_tab[0] = '{ch: 1, x: 16'h1234, y: 16'h1234};
    byp_tab[1] = '{ch: 0, x: 16'h7FFF, y: 16'h7FFF};
    byp_tab[2] = '{ch: 1, x: 16'h8000, y: 16'h8000};
    byp_tab[3] = '{ch: 0, x: 16'h0001, y: 16'h0001};
    byp_tab[4] = '{ch: 1, x: 16'hABCD, y: 16'hABCD};
    for (int c = 0; c < NC; c++) begin
      ch_cnt[c] = 0; r_m[c] = 0;
      for (int k = 0; k < TPP; k++) hist[c][k] = 0;
    end
    for (int a = 0; a < NT; a++) coef_m[a] = 0;

    bus.valid_in = 1'b0; bus.ch_in = '0; bus.filter_in = '0; bus.bypass = 1'b0;
    bus.coeff_wr_en = 1'b0; bus.coeff_addr = '0; bus.coeff_data_in = '0;

    // Reset state
    repeat (3) step();
    chk("rst_valid_out", bus.valid_out, 0);
    chk("rst_filter_out", bus.filter_out, 0);
    chk("rst_ch_out", bus.ch_out, 0);
    chk("rst_overflow", bus.overflow, 0);
    chk("rst_underflow", bus.underflow, 0);
    rst_n = 1'b1;

    // Impulse response through phase 0 only
    for (int a = 0; a < NT; a++) wcoef(a, (a == 0) ? 262144 : 0);
    base = out_cnt;
    for (int i = 0; i < 12; i++)
      drive(1'b1, 0, imp_tab[i].x, 1'b0, 0, 0, 1'b1, imp_tab[i].emit, imp_tab[i].y);
    drain();
    chk("impulse_cnt", out_cnt - base, 8);

    // Rate and random-coefficient filtering
    load_rand();
    base = out_cnt;
    for (int i = 0; i < 48; i++) send(0, DW'($urandom_range(0, 65535)));
    drain();
    chk("rate_cnt", out_cnt - base, 32);

    // Coefficient write coincident with a phase-0 sample, then more samples
    drive(1'b1, 0, 16'h3000, 1'b1, 0, 200000, 1'b0, 1'b0, '0);
    for (int i = 0; i < 6; i++) send(0, DW'($urandom_range(0, 65535)));
    drain();

    // Saturation
    for (int a = 0; a < NT; a++) wcoef(a, (a == 0 || a == 2) ? 262144 : 0);
    do_reset();
    bo = ovf_cnt; bu = unf_cnt;
    for (int i = 0; i < 12; i++) send(0, 16'h7FFF);
    for (int i = 0; i < 12; i++) send(0, 16'h8000);
    drain();
    chk("ovf_cnt", ovf_cnt - bo, 3);
    chk("unf_cnt", unf_cnt - bu, 3);

    // Reset mid-stream
    for (int i = 0; i < 10; i++) send(0, DW'($urandom_range(0, 65535)));
    do_reset();
    for (int i = 0; i < 3; i++) begin
      chk("post_rst_valid_out", bus.valid_out, 0);
      step();
    end
    drive(1'b1, 0, 16'h1111, 1'b0, 0, 0, 1'b1, 1'b1, 16'h1111);
    drive(1'b1, 0, 16'h2222, 1'b0, 0, 0, 1'b1, 1'b1, 16'h0000);
    drain();
`ifdef COEFF_RDBK_EN
    bus.coeff_addr = AW'(0);   #1; chk("rdbk_h0", bus.coeff_rd_data, 262144);
    bus.coeff_addr = AW'(1);   #1; chk("rdbk_h1", bus.coeff_rd_data, 0);
    bus.coeff_addr = AW'(2);   #1; chk("rdbk_h2", bus.coeff_rd_data, 262144);
    bus.coeff_addr = AW'(100); #1; chk("rdbk_oor", bus.coeff_rd_data, 0);
`else
    bus.coeff_addr = AW'(0);   #1; chk("rdbk_tied", bus.coeff_rd_data, 0);
`endif
    step();

    // TDM independence
    load_rand();
    do_reset();
    b0 = ch_cnt[0]; b1 = ch_cnt[1];
    for (int i = 0; i < 48; i++) begin
      send(0, DW'(i * 97 - 3000));
      send(1, 16'h0000);
    end
    drain();
    chk("tdm_ch0_cnt", ch_cnt[0] - b0, 32);
    chk("tdm_ch1_cnt", ch_cnt[1] - b1, 32);

    // Bypass: in-flight results dropped on entry, 1-cycle pass-through
    send(0, 16'h0F0F);
    send(0, 16'h7070);
    flush_future();
    bus.bypass = 1'b1;
    base = out_cnt;
    for (int i = 0; i < 5; i++)
      drive(1'b1, byp_tab[i].ch, byp_tab[i].x, 1'b0, 0, 0, 1'b1, 1'b1, byp_tab[i].y);
    step();
    step();
    chk("bypass_cnt", out_cnt - base, 5);
    bus.bypass = 1'b0;
    for (int i = 0; i < 12; i++) send(i % 2, DW'($urandom_range(0, 65535)));
    drain();
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/poly_frac_resampler.md
Name: poly_frac_resampler

Overview:
- Generalised rational L/M fractional decimator (L < M); supersedes the fixed 2/3 fractional decimator in the DFE filter array.
- Polyphase FIR with a runtime-writable prototype coefficient bank.
- Adds time-division multiplexing for N_CH channels, each with its own delay line and phase state.
- Sits between the front-end filter chain and the downstream rate stages; one input word per clk at most.

Parameters:
DATA_WIDTH, 16, sample width, signed Q(DATA_WIDTH-DATA_FRAC).DATA_FRAC
DATA_FRAC, 15, sample fractional bits
COEFF_WIDTH, 20, coefficient width, signed
COEFF_FRAC, 18, coefficient fractional bits
N_TAP, 72, prototype length; must be a multiple of L
L, 2, interpolation factor; 1 <= L < M
M, 3, decimation factor
N_CH, 2, TDM channel count, >= 1
CH_W, max(1,$clog2(N_CH)), channel-tag width (derived)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
valid_in  in  1  input sample strobe
ch_in  in  CH_W  channel tag of filter_in
filter_in  in  DATA_WIDTH  input sample
bypass  in  1  pass-through mode
coeff_wr_en  in  1  coefficient write strobe
coeff_addr  in  $clog2(N_TAP)  prototype tap index
coeff_data_in  in  COEFF_WIDTH  coefficient write data
coeff_rd_data  out  COEFF_WIDTH  coefficient at coeff_addr
filter_out  out  DATA_WIDTH  output sample
ch_out  out  CH_W  channel tag of filter_out
valid_out  out  1  output strobe
overflow  out  1  positive-saturation pulse, aligned with valid_out
underflow  out  1  negative-saturation pulse, aligned with valid_out

Behaviour:
- Clock and reset: one clock clk; reset rst_n is synchronous and active-low.
- Reset clears:
  - all delay lines and pipeline stages;
  - per-channel phase register r[ch] to 0;
  - valid_out, overflow, underflow, filter_out and ch_out to 0.
- Reset does not clear the coefficient bank. Power-up bank content is 0.
- Reset asserted mid-stream drops all in-flight results: valid_out is 0 from the cycle after the reset edge.
- Input acceptance: valid_in=1 shifts filter_in into delay line ch_in (TPP = N_TAP/L words per channel). ch_in >= N_CH: sample dropped, no state change.
- Phase control per channel, applied on each accepted sample:
  - if r[ch] < L: emit an output with phase p = r[ch], then r[ch] <= r[ch] + M - L;
  - else: no output, r[ch] <= r[ch] - L.
  - Result: at most one output per input; exactly L outputs per M inputs per channel; r in [0, M-1].
- Output computation:
  - y = sum over k=0..TPP-1 of h[k*L+p] * x[n-k], where x[n] is the sample just accepted.
  - Full-precision products; accumulator carries $clog2(TPP) guard bits.
- Rounding and saturation:
  - Round half-up: add 2^(COEFF_FRAC-1), then arithmetic shift right by COEFF_FRAC.
  - Saturate to DATA_WIDTH.
  - Clip high sets overflow=1; clip low sets underflow=1; both only on the valid_out cycle.
- Latency: 3 clk from valid_in to valid_out (delay-line register, product register, sum/round/saturate register). ch_out travels with the data.
- Coefficients:
  - coeff_wr_en writes coeff_data_in to h[coeff_addr] at the clock edge; an out-of-range address is ignored.
  - The new value is used from the next accepted sample.
  - Writes are legal while running; there is no interlock.
- bypass=1:
  - filter_out <= filter_in, ch_out <= ch_in, valid_out <= valid_in, with 1-cycle latency.
  - No decimation; overflow and underflow stay 0.
  - Delay lines keep shifting; r[] held at 0.
  - In-flight filtered results are discarded when bypass rises.
  - Leaving bypass starts every channel at phase 0.
- Simultaneous coeff write and valid_in: the sample uses the old coefficient.

Optional Feature:
- Macro COEFF_RDBK_EN.
- Defined: coeff_rd_data = h[coeff_addr] combinationally; out-of-range address returns 0.
- Undefined: coeff_rd_data tied to 0; no read mux synthesised.

Test Plan:
- Impulse: defaults; h[0]=0x40000 (1.0), rest 0; ch0 inputs 0x4000 then 0x0000 ×11 -> first valid_out 3 clk later with filter_out=0x4000, ch_out=0; remaining 7 outputs 0x0000.
- Rate: 48 consecutive ch0 samples -> exactly 32 valid_out pulses, pattern output/output/none repeating; r cycles 0,1,2.
- Saturation: h[0]=h[2]=0x40000, constant input 0x7FFF -> steady phase-0 outputs 0x7FFF with overflow=1. Input 0x8000 -> 0x8000 with underflow=1.
- TDM independence: alternate ch0 (ramp) and ch1 (zeros), 96 samples -> 32 outputs per channel; all ch1 outputs 0x0000; ch0 values identical to a single-channel run.
- Reset mid-stream: rst_n=0 for one clk after 10 inputs -> valid_out=0 for the next 3 clk regardless of prior inputs; first post-reset input emits phase 0; coefficients unchanged (readback with COEFF_RDBK_EN).
- Bypass: bypass=1, input 0x1234 on ch1 -> next clk filter_out=0x1234, ch_out=1, valid_out=1; every input produces an output.
